// File: rtl/prefix_adder_pipe.sv
// prefix_adder_pipe: pipelined Kogge-Stone adder/subtractor with valid/ready handshaking.
//
// Computes a + b + cin (sub = 0) or a - b (sub = 1, formed as a + ~b + 1). Carries come from a
// parallel-prefix generate/propagate network of log2(WIDTH) levels. The levels are split into
// STAGES register segments of at most ceil(log2(WIDTH)/STAGES) levels each. The final register
// holds sum/cout/ovf and drives the outputs directly.
//
// Parameters
//   WIDTH   operand width, a power of two in 4..64 (default 16)
//   STAGES  register stages / latency in cycles, 1..log2(WIDTH) (default 2)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand set present
//   in_ready   operand set accepted this cycle (independent of in_valid)
//   a, b       operands
//   cin        carry-in, ignored when sub = 1
//   sub        0: a + b + cin, 1: a - b
//   out_valid  result present
//   out_ready  downstream accepts the result
//   sum        result bits
//   cout       carry out of the MSB (for subtraction, 1 = no borrow)
//   ovf        two's-complement signed overflow
//
// Compile-time option
//   PREFIX_ADDER_SAT_EN  when defined, sum clamps to the most positive / most negative value on
//                        signed overflow; ovf and cout still report the unclamped event.

module prefix_adder_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned Levels = $clog2(WIDTH);
  localparam int unsigned Seg    = (Levels + STAGES - 1) / STAGES;
  localparam int unsigned Last   = STAGES - 1;

  if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("prefix_adder_pipe: WIDTH must be a power of two in 4..64");
  end
  if (STAGES < 1 || STAGES > Levels) begin : g_bad_stages
    $error("prefix_adder_pipe: STAGES must be in 1..log2(WIDTH)");
  end

  // Pipeline payload between prefix segments. g/p are the partially combined group terms, ps is
  // the per-bit propagate kept for the final sum XOR, ci is the effective carry-in.
  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] ps;
    logic             ci;
`ifdef PREFIX_ADDER_SAT_EN
    logic             amsb;
`endif
  } stage_t;

  // Applies the prefix levels owned by one segment. Level lv combines each bit with the group
  // 2**lv positions below it. Bits below that distance already span down to bit 0 and are kept;
  // their group propagate stays exact because the carry-in is merged only at the very end.
  function automatic logic [2*WIDTH-1:0] run_levels(input logic [WIDTH-1:0] g_in,
                                                    input logic [WIDTH-1:0] p_in,
                                                    input int unsigned      stage);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    int unsigned      lv;
    int unsigned      d;
    g = g_in;
    p = p_in;
    for (int unsigned j = 0; j < Seg; j++) begin
      lv = stage * Seg + j;
      if (lv < Levels) begin
        d = 32'd1 << lv;
        g = g | (p & (g << d));
        p = p & ((p << d) | ~({WIDTH{1'b1}} << d));
      end
    end
    return {g, p};
  endfunction

  // Operand conditioning: subtraction inverts b and forces the carry-in to 1.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  stage_t           pre;

  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;

  always_comb begin
    pre      = '0;
    pre.g    = a & b_eff;
    pre.p    = a ^ b_eff;
    pre.ps   = a ^ b_eff;
    pre.ci   = cin_eff;
`ifdef PREFIX_ADDER_SAT_EN
    pre.amsb = a[WIDTH-1];
`endif
  end

  // cur[s] is the payload entering segment s: the conditioned operands for s = 0, otherwise the
  // register of segment s-1.
  stage_t cur [STAGES];
  assign cur[0] = pre;

  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] load;
  logic              full;

  // A stage loads when it is empty or the stage after it loads; unrolled, stage k loads when the
  // output drains or any stage from k to the end holds a bubble. This lets interior bubbles
  // collapse while the output is stalled, and keeps in_ready independent of in_valid.
  always_comb begin
    full = 1'b1;
    load = '0;
    for (int k = int'(Last); k >= 0; k--) begin
      full    = full & valid[k];
      load[k] = ~full | out_ready;
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid[Last];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic             up_valid;
    logic             valid_q;
    logic [WIDTH-1:0] gs;
    logic [WIDTH-1:0] pgs;

    if (s == 0) begin : g_first
      assign up_valid = in_valid;
    end else begin : g_next
      assign up_valid = valid[s-1];
    end

    assign {gs, pgs} = run_levels(cur[s].g, cur[s].p, s);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
      end else if (load[s]) begin
        valid_q <= up_valid;
      end
    end

    assign valid[s] = valid_q;

    if (s < Last) begin : g_mid
      stage_t st_d;
      stage_t st_q;

      always_comb begin
        st_d   = cur[s];
        st_d.g = gs;
        st_d.p = pgs;
      end

      // Data only moves with a real operand so bubbles do not toggle the payload.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          st_q <= '0;
        end else if (load[s] && up_valid) begin
          st_q <= st_d;
        end
      end

      assign cur[s+1] = st_q;
    end else begin : g_last
      logic [WIDTH-1:0] carry;
      logic [WIDTH-1:0] sum_d;
      logic             cout_d;
      logic             ovf_d;
      logic [WIDTH-1:0] sum_q;
      logic             cout_q;
      logic             ovf_q;

      // Full prefixes are now available; fold in the carry-in as c[i+1] = G[i:0] | P[i:0] & ci.
      always_comb begin
        carry  = {gs[WIDTH-2:0] | (pgs[WIDTH-2:0] & {(WIDTH-1){cur[s].ci}}), cur[s].ci};
        cout_d = gs[WIDTH-1] | (pgs[WIDTH-1] & cur[s].ci);
        ovf_d  = carry[WIDTH-1] ^ cout_d;
        sum_d  = cur[s].ps ^ carry;
`ifdef PREFIX_ADDER_SAT_EN
        // Overflow can only happen when both addends share a sign, so a's MSB gives the direction.
        if (ovf_d) begin
          sum_d = cur[s].amsb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (load[s] && up_valid) begin
          sum_q  <= sum_d;
          cout_q <= cout_d;
          ovf_q  <= ovf_d;
        end
      end

      assign sum  = sum_q;
      assign cout = cout_q;
      assign ovf  = ovf_q;
    end
  end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Self-checking bench for prefix_adder_pipe (WIDTH = 16, STAGES = 2). Expected results come from
// a plain integer-arithmetic model; the saturating variant is selected by PREFIX_ADDER_SAT_EN.

module tb_prefix_adder_pipe;

  localparam int unsigned Width  = 16;
  localparam int unsigned Stages = 2;
  localparam int          NRand  = 10000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [Width-1:0]  a;
  logic [Width-1:0]  b;
  logic              cin;
  logic              sub;
  logic              out_valid;
  logic              out_ready;
  logic [Width-1:0]  sum;
  logic              cout;
  logic              ovf;

  int checks = 0;
  int errors = 0;

  logic [17:0] expq[$];

  prefix_adder_pipe #(
    .WIDTH (Width),
    .STAGES(Stages)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1);
  end

  // Reference: {cout, ovf, sum} from whole-number arithmetic.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mcin, input logic msub);
    logic [15:0] bb;
    logic [16:0] full;
    logic [15:0] s;
    logic        o;
    bb   = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + {16'd0, (msub ? 1'b1 : mcin)};
    s    = full[15:0];
    o    = (ma[15] == bb[15]) && (s[15] != ma[15]);
`ifdef PREFIX_ADDER_SAT_EN
    if (o) s = ma[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {full[16], o, s};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(7))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if ({cout, ovf, sum} !== 18'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 00000", {cout, ovf, sum});
    end
    rst_n = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1 0",
                         in_ready, out_valid);
    end
    step();
  endtask

  task automatic test_latency_wrap();
    int n;
    bit got;
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL wrap_accept: got in_ready=%b expected 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    n = 1; got = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      if (out_valid === 1'b1) got = 1;
      else begin step(); n++; end
    end
    checks++;
    if (!got || n != 2) begin
      errors++; $display("FAIL wrap_latency: got %0d cycles expected 2", n);
    end
    checks++;
    if ({cout, ovf, sum} !== {1'b1, 1'b0, 16'h0000}) begin
      errors++; $display("FAIL wrap_result: got %h expected %h", {cout, ovf, sum},
                         {1'b1, 1'b0, 16'h0000});
    end
    step();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_single: got out_valid=%b expected 0", out_valid);
    end
    step();
  endtask

  task automatic test_overflow();
    logic [15:0] ta [4] = '{16'h7FFF, 16'h8000, 16'h0005, 16'h0005};
    logic [15:0] tb [4] = '{16'h0001, 16'h0001, 16'h0003, 16'h0003};
    logic        tsub [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        tcin [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef PREFIX_ADDER_SAT_EN
    logic [15:0] es [4] = '{16'h7FFF, 16'h8000, 16'h0002, 16'h0009};
`else
    logic [15:0] es [4] = '{16'h8000, 16'h7FFF, 16'h0002, 16'h0009};
`endif
    logic        ec [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        eo [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int n;
    bit got;
    for (int i = 0; i < 4; i++) begin
      a = ta[i]; b = tb[i]; sub = tsub[i]; cin = tcin[i]; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      n = 1; got = 0;
      while (!got && n < 10) begin
        @(negedge clk);
        if (out_valid === 1'b1) got = 1;
        else begin step(); n++; end
      end
      checks++;
      if (!got || {cout, ovf, sum} !== {ec[i], eo[i], es[i]}) begin
        errors++; $display("FAIL ovf_vec%0d: got valid=%b %h expected %h", i, got,
                           {cout, ovf, sum}, {ec[i], eo[i], es[i]});
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int nout = 0;
    out_ready = 1'b0; sub = 1'b0; cin = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid = (idx < 4);
      a = 16'(idx + 1); b = 16'(idx + 1);
      @(negedge clk);
      if (cyc >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || sum !== 16'h0002 || in_ready !== 1'b0) begin
          errors++; $display("FAIL b2b_stall%0d: got valid=%b sum=%h in_ready=%b expected 1 0002 0",
                             cyc, out_valid, sum, in_ready);
        end
      end
      if (in_valid && in_ready === 1'b1) idx++;
      step();
    end
    checks++;
    if (idx != 2) begin
      errors++; $display("FAIL b2b_accepted: got %0d expected 2", idx);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 8 && nout < 4; cyc++) begin
      in_valid = (idx < 4);
      a = 16'(idx + 1); b = 16'(idx + 1);
      @(negedge clk);
      if (out_valid === 1'b1) begin
        checks++;
        if (sum !== 16'(2 * (nout + 1)) || cyc != nout) begin
          errors++; $display("FAIL b2b_drain%0d: got sum=%h at cycle %0d expected %h at cycle %0d",
                             nout, sum, cyc, 16'(2 * (nout + 1)), nout);
        end
        nout++;
      end
      if (in_valid && in_ready === 1'b1) idx++;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (nout != 4) begin
      errors++; $display("FAIL b2b_count: got %0d results expected 4", nout);
    end
  endtask

  task automatic test_reset_midflight();
    int n;
    bit got;
    out_ready = 1'b0; sub = 1'b0; cin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = 16'(i + 1); b = 16'(i + 1); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_flush: got out_valid=%b in_ready=%b expected 0 1",
                         out_valid, in_ready);
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_release: got out_valid=%b in_ready=%b expected 0 1",
                         out_valid, in_ready);
    end
    step();
    a = 16'h1234; b = 16'h0F0F; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n = 1; got = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      if (out_valid === 1'b1) got = 1;
      else begin step(); n++; end
    end
    checks++;
    if (!got || n != 2 || {cout, ovf, sum} !== {2'b00, 16'h2143}) begin
      errors++; $display("FAIL midrst_first: got %h after %0d cycles expected %h after 2",
                         {cout, ovf, sum}, n, {2'b00, 16'h2143});
    end
    step();
  endtask

  task automatic test_random();
    int nin = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [17:0] prev_word = '0;
    logic [17:0] got_w;
    logic [17:0] exp_w;
    expq.delete();
    while ((nin < NRand || expq.size() != 0) && cyc < 80000) begin
      if (nin < NRand) begin
        in_valid  = ($urandom_range(3) != 0);
        a         = pick();
        b         = pick();
        sub       = 1'($urandom_range(1));
        cin       = 1'($urandom_range(1));
        out_ready = 1'($urandom_range(1));
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      got_w = {cout, ovf, sum};
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || got_w !== prev_word) begin
          errors++; $display("FAIL rnd_hold: got valid=%b word=%h expected valid=1 word=%h",
                             out_valid, got_w, prev_word);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL rnd_extra: got word=%h expected no result", got_w);
        end else begin
          exp_w = expq.pop_front();
          if (got_w !== exp_w) begin
            errors++; $display("FAIL rnd_result: got %h expected %h", got_w, exp_w);
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        expq.push_back(model(a, b, cin, sub));
        nin++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_word  = got_w;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (nin < NRand || expq.size() != 0) begin
      errors++; $display("FAIL rnd_complete: got %0d accepted %0d pending expected %0d accepted 0 pending",
                         nin, expq.size(), NRand);
    end
  endtask

  initial begin
    test_reset();
    test_latency_wrap();
    test_overflow();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prefix_adder_pipe.md
PREFIX_ADDER_PIPE -- requirements
Module: prefix_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand width; SHALL be a power of two in 4..64.
REQ-002 Parameter STAGES, default 2, number of register stages; SHALL be in 1..log2(WIDTH).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion and active-low.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; ignored when sub=1.
REQ-010 sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 sum  output  WIDTH  result bits.
REQ-014 cout  output  1  carry out of MSB (for sub, 1 = no borrow).
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Carry computation SHALL use a parallel-prefix (generate/propagate) network of log2(WIDTH) levels, with g_i = a_i & b'_i, p_i = a_i ^ b'_i, where b' = sub ? ~b : b and the carry-in is sub ? 1 : cin.
REQ-017 Register boundaries SHALL be spread across the prefix levels so that no segment exceeds ceil(log2(WIDTH)/STAGES) levels; the last register SHALL drive sum/cout/ovf directly.
REQ-018 Transfer in SHALL occur when in_valid & in_ready; transfer out SHALL occur when out_valid & out_ready.
REQ-019 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with an unstalled pipeline.
REQ-020 Each stage k SHALL hold a valid bit; stage k SHALL load when its valid is 0 or stage k+1 loads (last stage: when out_valid is 0 or out_ready is 1).
REQ-021 in_ready SHALL equal the load condition of stage 0 and SHALL NOT depend combinationally on in_valid.
REQ-022 Throughput SHALL be one result per cycle while out_ready=1; interior bubbles SHALL collapse when downstream stalls.
REQ-023 While out_valid=1 and out_ready=0, sum/cout/ovf SHALL stay stable; no result SHALL be dropped, duplicated or reordered.
REQ-024 With the pipeline full and out_ready=0, in_ready SHALL be 0; a simultaneous output and input transfer on a full pipeline SHALL be accepted in the same cycle.
REQ-025 ovf SHALL equal carry into MSB XOR carry out of MSB.
REQ-026 Arithmetic SHALL wrap modulo 2^WIDTH (unless REQ-030 applies).

Reset
REQ-027 While rst_n=0: all stage valid bits, out_valid, sum, cout and ovf SHALL be 0; in_ready SHALL be 1 immediately after release.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight results; the first result after release SHALL come from the first post-reset transfer.

Configuration
REQ-029 Macro PREFIX_ADDER_SAT_EN SHALL select saturation logic at compile time.
REQ-030 Defined: on ovf=1 sum SHALL clamp to 0x7F..F (positive overflow, MSB of a=0) or 0x80..0 (negative overflow); ovf still reports the event; cout unchanged.
REQ-031 Undefined: no saturation logic SHALL be present; sum wraps per REQ-026.

Verification (WIDTH=16, STAGES=2)
REQ-032 a=0xFFFF, b=0x0001, sub=0, cin=0 -> sum=0x0000, cout=1, ovf=0, out_valid exactly 2 cycles after transfer.
REQ-033 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1; with PREFIX_ADDER_SAT_EN sum=0x7FFF. a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1; with macro sum=0x8000.
REQ-034 Back-to-back inputs 1+1, 2+2, 3+3, 4+4, out_ready held 0 for 5 cycles -> in_ready drops after 2 accepted, sum holds 0x0002; on release outputs 0x0002, 0x0004, 0x0006, 0x0008 in order, no gaps.
REQ-035 rst_n pulsed low with 2 results in flight -> out_valid=0 next cycle, in_ready=1 after release; the next result is the first post-reset input.
REQ-036 10000 random operand/sub/cin sets with random out_ready -> every result matches a reference model, in order, with no loss.
